// File: rtl/ysyx_25010008_mdu_if.sv
// +--------------------------------------------------------------------------+
// | ysyx_25010008_mdu_if : request/response bundle of the multiply/divide unit |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ysyx_25010008_mdu_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, funct3, operand1, operand2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, funct3, operand1, operand2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_25010008_mdu.sv
// +--------------------------------------------------------------------------+
// | ysyx_25010008_mdu : iterative RV M-extension multiply/divide unit        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_25010008_mdu #(
  parameter int XLEN = 32
) (
  input  logic               clock,
  input  logic               reset,
  ysyx_25010008_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;
  logic              neg_r;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   mag;
  logic              in_ready;
  logic              out_valid;
  logic [XLEN-1:0]   result;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;

  // Operand signedness per funct3: signed1 for 000/001/010/100/110, signed2 for 000/001/100/110
  logic            signed1, signed2, sign1, sign2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign signed1  = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign signed2  = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign sign1    = signed1 & bus.operand1[XLEN-1];
  assign sign2    = signed2 & bus.operand2[XLEN-1];
  assign mag1     = sign1 ? -bus.operand1 : bus.operand1;
  assign mag2     = sign2 ? -bus.operand2 : bus.operand2;
  assign div_zero = bus.funct3[2] & (bus.operand2 == '0);
  assign div_ovf  = bus.funct3[2] & ~bus.funct3[0]
                  & (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}})
                  & (bus.operand2 == {XLEN{1'b1}});
  assign special_res = div_zero ? (bus.funct3[1] ? bus.operand1 : {XLEN{1'b1}})
                                : (bus.funct3[1] ? {XLEN{1'b0}} : bus.operand1);

  // Shift-add step: add multiplicand to upper half when the multiplier LSB is set, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: the dividend shifts out of acc's low half while quotient bits shift in
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_next, quo_next;
  assign shifted  = {rem, acc[XLEN-1]};
  assign trial    = shifted - {1'b0, mag};
  assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {acc[XLEN-2:0], ~trial[XLEN]};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod    = neg ? -acc : acc;
  assign quo_fix = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix = neg_r ? -rem : rem;
  assign fix_res = !op[2] ? ((op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                          : (op[1] ? rem_fix : quo_fix);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      neg       <= 1'b0;
      neg_r     <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      mag       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (bus.flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op       <= bus.funct3;
            neg      <= sign1 ^ sign2;
            neg_r    <= sign1;
            cnt      <= '0;
            rem      <= '0;
            in_ready <= 1'b0;
            if (div_zero || div_ovf) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
              if (bus.funct3[2]) begin
                mag <= mag2;
                acc <= {{XLEN{1'b0}}, mag1};
              end else begin
                mag <= mag1;
                acc <= {{XLEN{1'b0}}, mag2};
              end
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            acc <= {acc[2*XLEN-1:XLEN], quo_next};
            rem <= rem_next;
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_ysyx_25010008_mdu.sv
// +--------------------------------------------------------------------------+
// | tb_ysyx_25010008_mdu : directed self-checking bench for the MDU          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_25010008_mdu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ysyx_25010008_mdu_if #(.XLEN(32)) bus ();

  ysyx_25010008_mdu #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one op, measure latency (1 = visible right after the accept edge), check and retire it
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    bus.funct3 = f; bus.operand1 = a; bus.operand2 = b; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.operand1 = '0; bus.operand2 = '0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, bus.result, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.funct3 = '0;
    bus.operand1 = '0; bus.operand2 = '0; bus.out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu");
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu");
    do_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
    do_op(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_by0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // Back-pressure: result must hold while out_ready stays low
    bus.funct3 = 3'b000; bus.operand1 = 32'd3; bus.operand2 = 32'd4; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    seen = 0;
    while (!bus.out_valid && seen < 100) begin step(); seen++; end
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_result", bus.result, 32'd12);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.funct3 = 3'b101; bus.operand1 = 32'd9; bus.operand2 = 32'd0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("next_accept_valid", {31'd0, bus.out_valid}, 32'd1);
    check("next_accept_res", bus.result, 32'hFFFF_FFFF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Flush during CALC
    bus.funct3 = 3'b000; bus.operand1 = 32'h1234; bus.operand2 = 32'h10; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE wins over a concurrent request
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.funct3 = 3'b101; bus.operand2 = 32'd0;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    do_op(3'b011, 32'd3, 32'd5, 32'd0, 34, "mulhu_after_flush");

    // Reset mid-operation clears the result register as well
    bus.funct3 = 3'b101; bus.operand1 = 32'd100; bus.operand2 = 32'd7; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_result", bus.result, 32'd0);
    check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
